// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Funct3 decode, FSM states, size and lane-mask helpers.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    RESP
  } state_t;

  function automatic logic [3:0] size_bytes(
    input logic [2:0] f3
  );
    return 4'd1 << f3[1:0];
  endfunction

  // Mask spans two words so a split access can take its upper half.
  function automatic logic [15:0] lane_mask(
    input logic [2:0] f3,
    input logic [2:0] off
  );
    return ((16'd1 << size_bytes(f3)) - 16'd1) << off;
  endfunction

  function automatic logic is_illegal(
    input logic [2:0] f3,
    input logic       we,
    input logic       dw64
  );
    return (f3 == 3'b111)
        || (!dw64 && (f3 == F3_D || f3 == F3_WU))
        || (we && f3[2]);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane word storage with registered read.
// One access per cycle; per-lane write enables.
module dmem_bank #(
  parameter int DATA_W = 32,
  parameter int IW     = 7
) (
  input  logic                clk,
  input  logic                en_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [IW-1:0]       idx_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NL = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**IW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < NL; i++) begin
        if (we_i[i]) begin
          mem[idx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Handshaked data memory with load/store unit.
// Lane steering, extension and two-beat misaligned split.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int NL = DATA_W / 8;
  localparam int L  = $clog2(NL);
  localparam int IW = ADDR_W - L;

  state_t            state_q;
  logic [2:0]        f3_q;
  logic              we_q, err_q, split_q, valid_q;
  logic [L-1:0]      off_q;
  logic [IW-1:0]     idx_q;
  logic [NL-1:0]     hmask_q;
  logic [DATA_W-1:0] hdata_q, beat0_q;

  logic [L-1:0]        off;
  logic [IW-1:0]       idx0;
  logic                illegal, mis, err_now, split, go, beat1;
  logic [2*NL-1:0]     mask2;
  logic [2*DATA_W-1:0] wide, cat;
  logic                bank_en;
  logic [NL-1:0]       bank_we;
  logic [IW-1:0]       bank_idx;
  logic [DATA_W-1:0]   bank_wd, bank_rd;
  logic [DATA_W-1:0]   raw, smask, top, ext;
  logic [6:0]          nbits;
  logic                neg;

  assign off     = req_addr[L-1:0];
  assign idx0    = req_addr[ADDR_W-1:L];
  assign illegal = is_illegal(req_funct3, req_we, DATA_W == 64);
  assign mis     = (5'(off) + 5'(size_bytes(req_funct3))) > 5'(NL);
  assign err_now = illegal || (mis && MISALIGN_EN == 0);
  assign split   = mis && !illegal;
  assign mask2   = (2*NL)'(lane_mask(req_funct3, 3'(off)));
  assign wide    = {{DATA_W{1'b0}}, req_wdata} << {off, 3'b000};

  // Gate with rst_n so a reset edge aborts a pending second beat.
  assign go    = (state_q == IDLE) && req_valid && !err_now && rst_n;
  assign beat1 = (state_q == BEAT1) && rst_n;

  assign bank_en  = go || beat1;
  assign bank_idx = beat1 ? idx_q : idx0;
  assign bank_wd  = beat1 ? hdata_q : wide[DATA_W-1:0];
  assign bank_we  = beat1 ? (we_q ? hmask_q : '0)
                          : (req_we ? mask2[NL-1:0] : '0);

  dmem_bank #(
    .DATA_W (DATA_W),
    .IW     (IW)
  ) u_bank (
    .clk     (clk),
    .en_i    (bank_en),
    .we_i    (bank_we),
    .idx_i   (bank_idx),
    .wdata_i (bank_wd),
    .rdata_o (bank_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid) begin
          f3_q    <= req_funct3;
          we_q    <= req_we;
          off_q   <= off;
          idx_q   <= idx0 + IW'(1);
          hmask_q <= mask2[2*NL-1:NL];
          hdata_q <= wide[2*DATA_W-1:DATA_W];
          err_q   <= err_now;
          split_q <= split;
          if (!err_now && split) begin
            state_q <= BEAT1;
          end else begin
            state_q <= RESP;
            valid_q <= 1'b1;
          end
        end
        BEAT1: begin
          beat0_q <= bank_rd;
          state_q <= RESP;
          valid_q <= 1'b1;
        end
        RESP: if (resp_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cat = split_q ? {bank_rd, beat0_q}
                       : {{DATA_W{1'b0}}, bank_rd};
  assign raw   = DATA_W'(cat >> {off_q, 3'b000});
  assign nbits = {size_bytes(f3_q), 3'b000};
  assign smask = ~({DATA_W{1'b1}} << nbits);
  assign top   = smask & ~(smask >> 1);
  assign neg   = !f3_q[2] && |(raw & top);
  assign ext   = neg ? (raw | ~smask) : (raw & smask);

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = valid_q;
  assign resp_err   = valid_q && err_q;
  assign resp_rdata = (valid_q && !err_q && !we_q) ? ext : '0;

endmodule
